// File: rtl/mvm_job_scheduler.sv
// mvm_job_scheduler: round-robin job arbiter in front of one shared
// matrix-vector multiplier, with issue/wait/respond sequencing and timeout.
module mvm_job_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               mvm_start,
  input  logic               mvm_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_owner,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] OWN_MAX = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] OH1 = NUM_REQ'(1);

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               found;
  logic [IW-1:0]      win;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] ready_d;
  logic               start_d;
  int                 idx;

  // round-robin pick: first pending requester at or after rr_q
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    win_oh = OH1 << win;
  end

  // next-state and per-state outputs
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    owner_d = owner_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ready_d = win_oh;
          grant_d = win_oh;
          owner_d = win;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mvm_done) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_d    = (owner_q == OWN_MAX) ? '0 : owner_q + 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = rst_n ? ready_d : '0;
  assign mvm_start = start_d;
  assign grant     = grant_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_owner = owner_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mvm_job_scheduler.sv
// tb_mvm_job_scheduler: scoreboard bench for the multiplier job scheduler.
// Expected responses are queued at accept and popped at rsp_valid.
module tb_mvm_job_scheduler;

  localparam int NR = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] grant;
  logic          mvm_start;
  logic          mvm_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_owner;
  logic          rsp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int readies = 0;
  int m_rr = 0;
  int sb_q[$];

  mvm_job_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .grant(grant), .mvm_start(mvm_start), .mvm_done(mvm_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_owner(rsp_owner), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // pulse counters seen by the edge
  always @(posedge clk) begin
    if (rst_n) begin
      if (mvm_start) starts++;
      if (|req_ready) readies++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int w);
    logic [1:0] r;
    r = 2'b00;
    r[w] = 1'b1;
    return r;
  endfunction

  function automatic int pick(input logic [1:0] v, input int rr);
    for (int i = 0; i < NR; i++) begin
      if (v[(rr + i) % NR]) return (rr + i) % NR;
    end
    return -1;
  endfunction

  task automatic job(input logic [1:0] vld, input int dly,
                     input int bp);
    int w, n, lat, e, st0, rd0, explat;
    bit err_e;
    st0 = starts;
    rd0 = readies;
    w = pick(vld, m_rr);
    err_e = (dly < 0) || (dly > TO);
    explat = err_e ? TO + 1 : dly + 1;
    req_valid = vld;
    rsp_ready = (bp == 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("accept", req_ready, oh(w));
    check("acc_grant0", grant, 2'b00);
    sb_q.push_back(w * 2 + int'(err_e));
    @(negedge clk); #1;
    check("start", mvm_start, 1'b1);
    check("grant", grant, oh(w));
    check("rdy_issue", req_ready, 2'b00);
    lat = 0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      mvm_done = (c == dly);
      #1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (mvm_start) check("restart", mvm_start, 1'b0);
    end
    check("latency", lat, explat);
    if (sb_q.size() == 0) begin
      check("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check("owner", rsp_owner, e / 2);
      check("err", rsp_err, e % 2);
    end
    check("grant_rsp", grant, oh(w));
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      mvm_done = (b == bp / 2);
      #1;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_grant", grant, oh(w));
      check("bp_ready", req_ready, 2'b00);
      check("bp_start", mvm_start, 1'b0);
      check("bp_err", rsp_err, err_e);
    end
    if (bp > 0) begin
      @(negedge clk);
      mvm_done = 1'b0;
      rsp_ready = 1'b1;
      #1;
    end
    mvm_done = 1'b0;
    req_valid = 2'b00;
    @(negedge clk); #1;
    check("idle_busy", busy, 1'b0);
    check("idle_grant", grant, 2'b00);
    check("n_start", starts - st0, 1);
    check("n_ready", readies - rd0, 1);
    m_rr = (w + 1) % NR;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    mvm_done = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_rspv", rsp_valid, 1'b0);
    check("rst_start", mvm_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    mvm_done = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
    #1;
    check("idle_done_busy", busy, 1'b0);
    check("idle_done_rsp", rsp_valid, 1'b0);

    for (int j = 0; j < 4; j++) job(2'b11, 4, 0);
    job(2'b01, 4, 0);
    job(2'b10, -1, 0);
    job(2'b01, 3, 0);
    job(2'b11, TO, 0);
    job(2'b11, TO + 1, 0);
    job(2'b11, 4, 10);
    job(2'b01, 2, 0);

    req_valid = 2'b10;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 1'b0);
    check("mr_grant", grant, 2'b00);
    check("mr_ready", req_ready, 2'b00);
    check("mr_start", mvm_start, 1'b0);
    check("mr_rspv", rsp_valid, 1'b0);
    check("mr_err", rsp_err, 1'b0);
    check("mr_owner", rsp_owner, 1'b0);
    sb_q.delete();
    m_rr = 0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mvm_done = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
    #1;
    check("spur_busy", busy, 1'b0);
    check("spur_rsp", rsp_valid, 1'b0);
    job(2'b11, 4, 0);
    job(2'b11, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_job_scheduler.md
MVM_JOB_SCHEDULER -- requirements
Module: mvm_job_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one matrix_vector_multiplier (2..8).
REQ-002 Parameter TIMEOUT, default 64, maximum cycles spent in WAIT for mvm_done (2..1023).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  bit k: requester k has a job pending; held until its req_ready.
REQ-006 req_ready  output  NUM_REQ  one-hot, one-cycle pulse: job of requester k accepted.
REQ-007 grant  output  NUM_REQ  one-hot owner of the multiplier; steers the external operand mux; zero when idle.
REQ-008 mvm_start  output  1  one-cycle start pulse to the multiplier.
REQ-009 mvm_done  input  1  multiplier completion pulse; result is valid in that cycle.
REQ-010 rsp_valid  output  1  response pending to the current owner.
REQ-011 rsp_ready  input  1  owner accepts the response.
REQ-012 rsp_owner  output  $clog2(NUM_REQ), min 1  index of the owner.
REQ-013 rsp_err  output  1  response is a timeout; the result is invalid.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESPOND.
REQ-016 IDLE: if any req_valid is high, select winner w by round-robin from pointer rr_ptr; scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Same edge: grant<=onehot(w), rsp_owner<=w, next state ISSUE.
- Same cycle: req_ready[w]=1 (combinational, one cycle only).
REQ-017 ISSUE: mvm_start=1 for exactly one cycle; clear timeout counter; next WAIT.
REQ-018 WAIT: counter increments each cycle.
- mvm_done=1: next RESPOND with rsp_err<=0.
- Counter reaches TIMEOUT-1 without mvm_done: next RESPOND with rsp_err<=1.
- mvm_done and the timeout in the same cycle: done wins, rsp_err=0.
REQ-019 RESPOND: rsp_valid=1; rsp_owner and rsp_err hold stable until rsp_ready.
- On rsp_valid and rsp_ready: rr_ptr<=(owner+1) mod NUM_REQ, grant<=0, next IDLE.
REQ-020 grant holds constant from ISSUE through RESPOND.
REQ-021 mvm_done is ignored outside WAIT.
REQ-022 req_valid changes outside IDLE have no effect.
REQ-023 Nominal throughput: multiplier done arrives 4 cycles after mvm_start.
- Job latency, accept to rsp_valid: 1 + 1 + 4 cycles.
- The earliest next accept is the cycle after rsp_ready.
REQ-024 A requester dropping req_valid before acceptance is not served; no state change.
REQ-025 At most one job is outstanding; mvm_start never reasserts before RESPOND completes.

Reset
REQ-026 rst_n low, at any time including mid-job, forces immediately:
- state IDLE, rr_ptr=0, grant=0, req_ready=0, mvm_start=0;
- rsp_valid=0, rsp_err=0, rsp_owner=0, busy=0;
- timeout counter=0.
REQ-027 After rst_n deasserts, the first arbitration occurs on the first posedge with req_valid nonzero; there are no stale responses.

Verification
REQ-028 Single job: req_valid=01, mvm_done 4 cycles after mvm_start, rsp_ready=1 -> response:
- req_ready=01 at cycle 0, mvm_start at cycle 1;
- rsp_valid at cycle 6, rsp_owner=0, rsp_err=0;
- rr_ptr=1.
REQ-029 Fairness: req_valid=11 held for 4 jobs -> grant sequence 01,10,01,10; exactly one req_ready pulse per job.
REQ-030 Timeout: TIMEOUT=8, mvm_done never asserted -> rsp_valid with rsp_err=1 exactly 8 cycles after entering WAIT; the next job proceeds normally.
REQ-031 Back-pressure: rsp_ready=0 for 10 cycles in RESPOND -> rsp_valid and grant stable; no mvm_start; no req_ready despite req_valid=11.
REQ-032 Reset mid-job: rst_n low during WAIT -> all outputs reset in the same cycle; a spurious mvm_done after release is ignored; the next request is served from requester 0.
REQ-033 Boundaries:
- mvm_done pulsed during IDLE or RESPOND -> no effect.
- mvm_done coincident with the timeout cycle -> rsp_err=0.
